alu_param_core: RTL and testbench
=================================

// Module: alu_param_core
// PURPOSE
//  Parametrised, registered ALU core; the next generation of the 8-bit ALU DUT behind alu_if.
//  Generalises operand width and adds three behaviours: split-operand collection with timeout,
//  a multi-cycle multiply path, and a res_valid/busy handshake. Sits between the stimulus
//  interface (drv_cb side) and the monitor/scoreboard (mon_cb side).
// PARAMETERS
//  WIDTH    8   operand width; res is WIDTH+1 bits, or 2*WIDTH for multiply
//  TIMEOUT  16  cycles to wait for the missing operand of a two-operand op
//  MUL_LAT  3   cycles from operand capture to multiply result (>=2)
// PORTS
//  clk        in   1          single clock, all state on posedge
//  rst        in   1          asynchronous, active-high reset
//  ce         in   1          clock enable; 0 freezes all state, timers and outputs
//  mode       in   1          1=arithmetic, 0=logical
//  cmd        in   4          opcode (see BEHAVIOUR)
//  inp_valid  in   2          [0]=op_a valid, [1]=op_b valid
//  op_a,op_b  in   WIDTH      operands
//  cin        in   1          carry-in for ADD_CIN/SUB_CIN
//  res        out  2*WIDTH    result, zero-extended
//  cout,oflow out  1          carry / borrow-underflow flags
//  G,E,L      out  1          compare flags, CMP only, else 0
//  err        out  1          illegal cmd, timeout, or rotate amount out of range
//  res_valid  out  1          1-cycle pulse: res/flags updated this cycle
//  busy       out  1          1 while collecting operands or multiplying; new cmds ignored
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timer=0; asserting rst mid-op aborts it, no res_valid.
//  Arith cmds: 0 ADD,1 SUB,2 ADD_CIN,3 SUB_CIN,4 INC_A,5 DEC_A,6 INC_B,7 DEC_B,8 CMP,
//   9 MUL_INC=(a+1)*(b+1), 10 MUL_SHL=(a<<1)*b (mod 2^(2W)). 11-15 illegal.
//  Logic cmds: 0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 NOT_A,7 NOT_B,8 SHR1_A,9 SHL1_A,
//   10 SHR1_B,11 SHL1_B,12 ROL_A_B,13 ROR_A_B. 14-15 illegal.
//  Logic results: WIDTH bits, zero-extended. Rotate amount = op_b[$clog2(WIDTH)-1:0];
//   any higher op_b bit set -> err=1, rotated res still driven.
//  Add/sub: W+1-bit sum; cout=bit W on ADD/ADD_CIN/INC; oflow=1 on SUB/SUB_CIN/DEC when
//   result underflows (a < b+cin).
//  CMP: exactly one of G/E/L set, unsigned compare; res=0.
//  Single-operand cmds need only their operand bit; two-operand cmds need both.
//  FSM (sub-module): IDLE -> EXEC if required operands valid in one cycle;
//   IDLE -> WAIT if one of two arrives (latch it, timer=0); WAIT -> EXEC when the other
//   arrives (cmd/mode taken from the IDLE cycle); WAIT -> IDLE with err=1, res_valid=1,
//   res=0 when timer reaches TIMEOUT; inp_valid=00 in IDLE -> no action.
//  Latency: non-mul result + res_valid exactly 1 cycle after operands are complete;
//   mul = MUL_LAT cycles. busy=1 in WAIT and in MUL; inputs ignored while busy.
//  Illegal cmd: err=1, res_valid=1, res=0, 1-cycle latency, no operand wait.
//  ce=0: hold res/flags; res_valid forced 0; timer and mul pipeline frozen.
//  Outputs keep their value until the next res_valid.
// STRUCTURE
//  alu_pkg: WIDTH-independent cmd enums (arith_cmd_e, logic_cmd_e), state typedef
//   (IDLE/WAIT/EXEC/MUL), helpers is_two_op(), is_mul(), is_legal().
//  Sub-module alu_op_collector: FSM, operand latches, timeout counter, busy.
//  Top: datapath, MUL_LAT-deep multiply shift register, output registers.
// TESTING (WIDTH=8)
//  ADD a=8'hFF b=8'h01 inp_valid=11 -> next cycle res=9'h100 cout=1 res_valid=1
//  SUB a=3 b=5 -> res=9'h1FE oflow=1; CMP a=5 b=5 -> E=1 G=0 L=0
//  ADD inp_valid=01 then 10 after 4 cycles -> result 1 cycle later, busy high throughout
//  ADD inp_valid=01 then 00 for 16 cycles -> err=1 res_valid=1 res=0, busy drops
//  MUL_INC a=3 b=4 -> res=20 after 3 cycles; cmd during busy ignored; ce=0 mid-mul stalls
//  ROL a=8'h81 b=8'h01 -> res=8'h03; b=8'h10 -> err=1; rst mid-WAIT -> outputs 0, no pulse

Source files
------------

// File: rtl/alu_pkg.sv
// Shared command encodings, collector states and opcode classification helpers
// for the parametrised ALU core. Everything here is independent of WIDTH.
package alu_pkg;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXEC, ST_MUL} state_e;

    // Operand bits an opcode needs: [0]=op_a, [1]=op_b; 2'b00 marks an illegal opcode.
    function automatic logic [1:0] need_ops(input logic mode, input logic [3:0] cmd);
        logic [1:0] m;
        m = 2'b00;
        if (mode) begin
            case (arith_cmd_e'(cmd))
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN,
                A_CMP, A_MUL_INC, A_MUL_SHL:     m = 2'b11;
                A_INC_A, A_DEC_A:                m = 2'b01;
                A_INC_B, A_DEC_B:                m = 2'b10;
                default:                         m = 2'b00;
            endcase
        end else begin
            case (logic_cmd_e'(cmd))
                L_AND, L_NAND, L_OR, L_NOR, L_XOR,
                L_XNOR, L_ROL_A_B, L_ROR_A_B:    m = 2'b11;
                L_NOT_A, L_SHR1_A, L_SHL1_A:     m = 2'b01;
                L_NOT_B, L_SHR1_B, L_SHL1_B:     m = 2'b10;
                default:                         m = 2'b00;
            endcase
        end
        return m;
    endfunction

    function automatic logic is_two_op(input logic mode, input logic [3:0] cmd);
        return need_ops(mode, cmd) == 2'b11;
    endfunction

    function automatic logic is_legal(input logic mode, input logic [3:0] cmd);
        return need_ops(mode, cmd) != 2'b00;
    endfunction

    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == 4'(A_MUL_INC)) || (cmd == 4'(A_MUL_SHL)));
    endfunction

endpackage

// File: rtl/alu_op_collector.sv
// Operand collection FSM: launches complete operations, parks a half-arrived
// two-operand op in WAIT with a timeout, and holds off new commands while busy.
module alu_op_collector
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             mode_i,
    input  logic [3:0]       cmd_i,
    input  logic [1:0]       inp_valid_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
    input  logic             mul_done_i,
    output logic             go_o,
    output logic             err_o,
    output logic             mode_o,
    output logic [3:0]       cmd_o,
    output logic             cin_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             busy_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       have_q, have_d;
    logic             mode_q, mode_d, cin_q, cin_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       need;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        have_d  = have_q;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        go_o    = 1'b0;
        err_o   = 1'b0;
        mode_o  = mode_i;
        cmd_o   = cmd_i;
        cin_o   = cin_i;
        a_o     = op_a_i;
        b_o     = op_b_i;
        need    = need_ops(mode_i, cmd_i);
        case (state_q)
            ST_IDLE, ST_EXEC: begin
                state_d = ST_IDLE;
                if (inp_valid_i != 2'b00) begin
                    if (!is_legal(mode_i, cmd_i)) begin
                        err_o = 1'b1;
                    end else if ((inp_valid_i & need) == need) begin
                        go_o    = 1'b1;
                        state_d = is_mul(mode_i, cmd_i) ? ST_MUL : ST_EXEC;
                    end else if (is_two_op(mode_i, cmd_i)) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                        have_d  = inp_valid_i;
                        mode_d  = mode_i;
                        cmd_d   = cmd_i;
                        cin_d   = cin_i;
                        a_d     = op_a_i;
                        b_d     = op_b_i;
                    end
                end
            end
            ST_WAIT: begin
                // The command context was frozen when the first operand arrived.
                mode_o = mode_q;
                cmd_o  = cmd_q;
                cin_o  = cin_q;
                a_o    = have_q[0] ? a_q : op_a_i;
                b_o    = have_q[1] ? b_q : op_b_i;
                if ((inp_valid_i & ~have_q) != 2'b00) begin
                    go_o    = 1'b1;
                    state_d = is_mul(mode_q, cmd_q) ? ST_MUL : ST_EXEC;
                end else if (timer_q == T_LAST) begin
                    err_o   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_MUL: begin
                if (mul_done_i) state_d = ST_EXEC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            have_q  <= 2'b00;
            mode_q  <= 1'b0;
            cmd_q   <= 4'd0;
            cin_q   <= 1'b0;
        end else if (ce_i) begin
            state_q <= state_d;
            timer_q <= timer_d;
            have_q  <= have_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cin_q   <= cin_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign busy_o = (state_q == ST_WAIT) || (state_q == ST_MUL);

endmodule

// File: rtl/alu_param_core.sv
// Registered ALU core: single-cycle arithmetic/logic datapath, a MUL_LAT-deep
// multiply pipeline and output registers that hold until the next res_valid.
module alu_param_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 mode,
    input  logic [3:0]           cmd,
    input  logic [1:0]           inp_valid,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 cin,
    output logic [2*WIDTH-1:0]   res,
    output logic                 cout,
    output logic                 oflow,
    output logic                 G,
    output logic                 E,
    output logic                 L,
    output logic                 err,
    output logic                 res_valid,
    output logic                 busy
);

    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);
    localparam int MD = MUL_LAT - 1;

    logic             go, ev_err, c_mode, c_cin, mul_done;
    logic [3:0]       c_cmd;
    logic [WIDTH-1:0] ca, cb;

    alu_op_collector #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_collector (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .mode_i(mode), .cmd_i(cmd),
        .inp_valid_i(inp_valid), .op_a_i(op_a), .op_b_i(op_b), .cin_i(cin),
        .mul_done_i(mul_done), .go_o(go), .err_o(ev_err), .mode_o(c_mode),
        .cmd_o(c_cmd), .cin_o(c_cin), .a_o(ca), .b_o(cb), .busy_o(busy)
    );

    logic [WIDTH:0]   ax, bx, cx, s;
    logic [WIDTH-1:0] lg;
    logic [RW-1:0]    rot, dp_res, aw, bw, mul_res;
    logic [SW-1:0]    amt;
    logic             dp_cout, dp_oflow, dp_g, dp_e, dp_l, dp_err;

    always_comb begin
        ax       = {1'b0, ca};
        bx       = {1'b0, cb};
        cx       = {{WIDTH{1'b0}}, c_cin};
        s        = '0;
        lg       = '0;
        rot      = '0;
        amt      = cb[SW-1:0];
        dp_res   = '0;
        dp_cout  = 1'b0;
        dp_oflow = 1'b0;
        dp_g     = 1'b0;
        dp_e     = 1'b0;
        dp_l     = 1'b0;
        dp_err   = 1'b0;
        if (c_mode) begin
            case (arith_cmd_e'(c_cmd))
                A_ADD:     begin s = ax + bx;      dp_cout = s[WIDTH]; end
                A_SUB:     begin s = ax - bx;      dp_oflow = ax < bx; end
                A_ADD_CIN: begin s = ax + bx + cx; dp_cout = s[WIDTH]; end
                A_SUB_CIN: begin s = ax - bx - cx; dp_oflow = ax < (bx + cx); end
                A_INC_A:   begin s = ax + (WIDTH+1)'(1); dp_cout = s[WIDTH]; end
                A_DEC_A:   begin s = ax - (WIDTH+1)'(1); dp_oflow = (ca == '0); end
                A_INC_B:   begin s = bx + (WIDTH+1)'(1); dp_cout = s[WIDTH]; end
                A_DEC_B:   begin s = bx - (WIDTH+1)'(1); dp_oflow = (cb == '0); end
                A_CMP:     begin dp_g = ca > cb; dp_e = ca == cb; dp_l = ca < cb; end
                default:   ;
            endcase
            dp_res = RW'(s);
        end else begin
            case (logic_cmd_e'(c_cmd))
                L_AND:     lg = ca & cb;
                L_NAND:    lg = ~(ca & cb);
                L_OR:      lg = ca | cb;
                L_NOR:     lg = ~(ca | cb);
                L_XOR:     lg = ca ^ cb;
                L_XNOR:    lg = ~(ca ^ cb);
                L_NOT_A:   lg = ~ca;
                L_NOT_B:   lg = ~cb;
                L_SHR1_A:  lg = ca >> 1;
                L_SHL1_A:  lg = ca << 1;
                L_SHR1_B:  lg = cb >> 1;
                L_SHL1_B:  lg = cb << 1;
                // Rotating the doubled operand lets one shifter cover every amount.
                L_ROL_A_B: begin rot = {ca, ca} << amt; lg = rot[RW-1:WIDTH]; dp_err = |(cb >> SW); end
                L_ROR_A_B: begin rot = {ca, ca} >> amt; lg = rot[WIDTH-1:0];  dp_err = |(cb >> SW); end
                default:   ;
            endcase
            dp_res = RW'(lg);
        end
    end

    always_comb begin
        aw      = RW'(ca);
        bw      = RW'(cb);
        mul_res = (c_cmd == 4'(A_MUL_INC)) ? (aw + RW'(1)) * (bw + RW'(1))
                                           : (aw << 1) * bw;
    end

    // Multiply pipeline: product enters at operand capture, drains to the outputs MUL_LAT-1 edges later.
    logic [MD-1:0] mvld_q;
    logic [RW-1:0] mpipe_q [MD];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mvld_q <= '0;
        end else if (ce) begin
            mvld_q[0] <= go && is_mul(c_mode, c_cmd);
            for (int k = 1; k < MD; k++) mvld_q[k] <= mvld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            mpipe_q[0] <= mul_res;
            for (int k = 1; k < MD; k++) mpipe_q[k] <= mpipe_q[k-1];
        end
    end

    assign mul_done = mvld_q[MD-1];

    // Output stage: results and flags hold between res_valid pulses.
    logic [RW-1:0] res_q;
    logic cout_q, oflow_q, g_q, e_q, l_q, err_q, res_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0; g_q <= 1'b0;
            e_q <= 1'b0; l_q <= 1'b0; err_q <= 1'b0; res_valid_q <= 1'b0;
        end else if (!ce) begin
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (ev_err) begin
                res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0; g_q <= 1'b0;
                e_q <= 1'b0; l_q <= 1'b0; err_q <= 1'b1; res_valid_q <= 1'b1;
            end else if (go && !is_mul(c_mode, c_cmd)) begin
                res_q <= dp_res; cout_q <= dp_cout; oflow_q <= dp_oflow; g_q <= dp_g;
                e_q <= dp_e; l_q <= dp_l; err_q <= dp_err; res_valid_q <= 1'b1;
            end else if (mul_done) begin
                res_q <= mpipe_q[MD-1]; cout_q <= 1'b0; oflow_q <= 1'b0; g_q <= 1'b0;
                e_q <= 1'b0; l_q <= 1'b0; err_q <= 1'b0; res_valid_q <= 1'b1;
            end
        end
    end

    assign res       = res_q;
    assign cout      = cout_q;
    assign oflow     = oflow_q;
    assign G         = g_q;
    assign E         = e_q;
    assign L         = l_q;
    assign err       = err_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_param_core.sv
// Scoreboard bench for alu_param_core at WIDTH=8: expected results are queued
// when an operation is driven and retired against each res_valid pulse.
module tb_alu_param_core;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int TO = 16;
    localparam int ML = 3;

    logic         clk = 1'b0;
    logic         rst, ce, mode, cin;
    logic [3:0]   cmd;
    logic [1:0]   inp_valid;
    logic [W-1:0] op_a, op_b;
    logic [2*W-1:0] res;
    logic         cout, oflow, G, E, L, err, res_valid, busy;

    alu_param_core #(.WIDTH(W), .TIMEOUT(TO), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd),
        .inp_valid(inp_valid), .op_a(op_a), .op_b(op_b), .cin(cin),
        .res(res), .cout(cout), .oflow(oflow), .G(G), .E(E), .L(L),
        .err(err), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic cout, oflow, g, e, l, err;
        int   due;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [15:0] r, input logic co, input logic ov, input logic g,
                        input logic e, input logic l, input logic er, input int lat);
        exp_t x;
        x.res = r; x.cout = co; x.oflow = ov; x.g = g; x.e = e; x.l = l; x.err = er;
        x.due = cyc + lat;
        sb.push_back(x);
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic [1:0] iv);
        mode = m; cmd = c; op_a = a; op_b = b; cin = ci; inp_valid = iv;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference behaviour written with plain integer arithmetic; due holds the latency.
    function automatic exp_t model(input logic m, input logic [3:0] c, input logic [7:0] a,
                                   input logic [7:0] b, input logic ci);
        exp_t x;
        int ai, bi, cii, r, k;
        ai = a; bi = b; cii = ci; r = 0; k = bi % 8;
        x.res = 0; x.cout = 0; x.oflow = 0; x.g = 0; x.e = 0; x.l = 0; x.err = 0; x.due = 1;
        if (m) begin
            case (c)
                4'd0:  begin r = ai + bi;       x.cout = (r > 255); end
                4'd1:  begin r = ai - bi;       x.oflow = (ai < bi); end
                4'd2:  begin r = ai + bi + cii; x.cout = (r > 255); end
                4'd3:  begin r = ai - bi - cii; x.oflow = (ai < bi + cii); end
                4'd4:  begin r = ai + 1;        x.cout = (r > 255); end
                4'd5:  begin r = ai - 1;        x.oflow = (ai == 0); end
                4'd6:  begin r = bi + 1;        x.cout = (r > 255); end
                4'd7:  begin r = bi - 1;        x.oflow = (bi == 0); end
                4'd8:  begin x.g = (ai > bi); x.e = (ai == bi); x.l = (ai < bi); end
                4'd9:  begin r = (ai + 1) * (bi + 1); x.due = ML; end
                4'd10: begin r = 2 * ai * bi;         x.due = ML; end
                default: x.err = 1;
            endcase
            x.res = (x.due == ML) ? 16'(r & 32'hFFFF) : 16'(r & 32'h1FF);
        end else begin
            case (c)
                4'd0:  r = ai & bi;
                4'd1:  r = ~(ai & bi);
                4'd2:  r = ai | bi;
                4'd3:  r = ~(ai | bi);
                4'd4:  r = ai ^ bi;
                4'd5:  r = ~(ai ^ bi);
                4'd6:  r = ~ai;
                4'd7:  r = ~bi;
                4'd8:  r = ai >> 1;
                4'd9:  r = ai << 1;
                4'd10: r = bi >> 1;
                4'd11: r = bi << 1;
                4'd12: begin r = (ai << k) | (ai >> (8 - k)); x.err = (bi > 7); end
                4'd13: begin r = (ai >> k) | (ai << (8 - k)); x.err = (bi > 7); end
                default: x.err = 1;
            endcase
            x.res = 16'(r & 32'hFF);
        end
        return x;
    endfunction

    exp_t m_e;
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("res",     32'(res),   32'(m_e.res));
                check("cout",    32'(cout),  32'(m_e.cout));
                check("oflow",   32'(oflow), 32'(m_e.oflow));
                check("GEL",     32'({G, E, L}), 32'({m_e.g, m_e.e, m_e.l}));
                check("err",     32'(err),   32'(m_e.err));
                check("latency", 32'(cyc),   32'(m_e.due));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t       x;
        logic       rm, rci;
        logic [3:0] rc;
        logic [7:0] ra, rb;

        rst = 1'b1; ce = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        step(2);
        check("rst_res",   32'(res), 32'd0);
        check("rst_flags", 32'({cout, oflow, G, E, L, err, res_valid, busy}), 32'd0);
        rst = 1'b0;
        step(1);

        // Directed single-cycle ops
        drive(1'b1, A_ADD, 8'hFF, 8'h01, 1'b0, 2'b11); push(16'h100, 1, 0, 0, 0, 0, 0, 1); step(1);
        drive(1'b1, A_SUB, 8'h03, 8'h05, 1'b0, 2'b11); push(16'h1FE, 0, 1, 0, 0, 0, 0, 1); step(1);
        drive(1'b1, A_CMP, 8'h05, 8'h05, 1'b0, 2'b11); push(16'h000, 0, 0, 0, 1, 0, 0, 1); step(1);
        inp_valid = 2'b00; step(1);

        // Split operands: a first, b four cycles later; cmd/a changed meanwhile
        drive(1'b1, A_ADD, 8'h10, 8'h00, 1'b0, 2'b01); step(1);
        check("wait_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, A_SUB, 8'hEE, 8'h00, 1'b0, 2'b00); step(1);
            check("wait_busy_hold", 32'(busy), 32'd1);
        end
        drive(1'b1, A_SUB, 8'hEE, 8'h22, 1'b0, 2'b10); push(16'h032, 0, 0, 0, 0, 0, 0, 1); step(1);
        check("wait_done_busy", 32'(busy), 32'd0);
        inp_valid = 2'b00; step(1);

        // Timeout waiting for op_b
        drive(1'b1, A_ADD, 8'h05, 8'h00, 1'b0, 2'b01); push(16'h000, 0, 0, 0, 0, 0, 1, TO + 1); step(1);
        inp_valid = 2'b00;
        check("timeout_busy_start", 32'(busy), 32'd1);
        step(TO - 1);
        check("timeout_busy_last", 32'(busy), 32'd1);
        step(1);
        check("timeout_busy_drop", 32'(busy), 32'd0);
        step(1);

        // Multiply with a command offered while busy
        drive(1'b1, A_MUL_INC, 8'd3, 8'd4, 1'b0, 2'b11); push(16'd20, 0, 0, 0, 0, 0, 0, ML); step(1);
        check("mul_busy", 32'(busy), 32'd1);
        drive(1'b1, A_ADD, 8'h11, 8'h22, 1'b0, 2'b11); step(1);
        check("mul_busy_ignore", 32'(busy), 32'd1);
        inp_valid = 2'b00; step(1);
        check("mul_done_busy", 32'(busy), 32'd0);
        step(1);

        // Multiply stalled by two ce=0 cycles
        drive(1'b1, A_MUL_SHL, 8'h81, 8'h03, 1'b0, 2'b11); push(16'h0306, 0, 0, 0, 0, 0, 0, ML + 2); step(1);
        inp_valid = 2'b00; ce = 1'b0; step(1);
        check("ce_hold_res", 32'(res), 32'h14);
        check("ce_busy", 32'(busy), 32'd1);
        step(1);
        ce = 1'b1; step(2);
        check("ce_mul_busy_drop", 32'(busy), 32'd0);

        // Rotates and illegal opcodes, back to back
        drive(1'b0, L_ROL_A_B, 8'h81, 8'h01, 1'b0, 2'b11); push(16'h03, 0, 0, 0, 0, 0, 0, 1); step(1);
        drive(1'b0, L_ROL_A_B, 8'h81, 8'h10, 1'b0, 2'b11); push(16'h81, 0, 0, 0, 0, 0, 1, 1); step(1);
        drive(1'b0, L_ROR_A_B, 8'h81, 8'h02, 1'b0, 2'b11); push(16'h60, 0, 0, 0, 0, 0, 0, 1); step(1);
        drive(1'b1, 4'd12,     8'h12, 8'h34, 1'b0, 2'b01); push(16'h00, 0, 0, 0, 0, 0, 1, 1); step(1);
        drive(1'b0, 4'd15,     8'h12, 8'h34, 1'b0, 2'b10); push(16'h00, 0, 0, 0, 0, 0, 1, 1); step(1);
        inp_valid = 2'b00; step(1);

        // Reset while waiting for an operand
        drive(1'b1, A_ADD, 8'h07, 8'h00, 1'b0, 2'b01); step(1);
        check("rstwait_busy", 32'(busy), 32'd1);
        inp_valid = 2'b00; rst = 1'b1; #1;
        check("rstwait_res",   32'(res), 32'd0);
        check("rstwait_flags", 32'({cout, oflow, G, E, L, err, res_valid, busy}), 32'd0);
        step(1);
        rst = 1'b0;
        step(TO + 4);
        check("rstwait_idle", 32'(busy), 32'd0);

        // Random single-shot operations
        for (int i = 0; i < 60; i++) begin
            rm  = 1'($urandom_range(0, 1));
            rc  = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = (i % 4 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            rci = 1'($urandom_range(0, 1));
            x = model(rm, rc, ra, rb, rci);
            push(x.res, x.cout, x.oflow, x.g, x.e, x.l, x.err, x.due);
            drive(rm, rc, ra, rb, rci, 2'b11);
            step(1);
            inp_valid = 2'b00;
            if (x.due > 1) step(x.due - 1);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
